// File: rtl/npu_result_reader_pkg.sv
// -----------------------------------------------------------------------------
// npu_result_reader_pkg
//   Shared constants, FSM state encoding and helpers for the NPU result reader.
//   Contents:
//     FRAME_BYTES         - bytes per result frame (two 16-bit MAC words)
//     TIMEOUT_CYCLES_DEF  - default partial-frame timeout in cycles
//     BCNT_W / TO_W       - widths of the byte counter and timeout counter
//     rr_state_e          - reader FSM states (FETCH, PRESENT)
//     res_index_f()       - signed 16-bit argmax of the two MAC words
// -----------------------------------------------------------------------------
package npu_result_reader_pkg;

    localparam int FRAME_BYTES        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int BCNT_W             = 2;
    localparam int TO_W               = 8;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        PRESENT = 1'b1
    } rr_state_e;

    // Returns 1 when mac1 is strictly greater than mac0 (two's complement).
    // Equal values pick index 0.
    function automatic logic res_index_f(input logic [15:0] mac0,
                                         input logic [15:0] mac1);
        return ($signed(mac0) < $signed(mac1));
    endfunction

endpackage

// File: rtl/npu_result_reader_if.sv
// -----------------------------------------------------------------------------
// npu_result_reader_if
//   Bus bundle between the NPU output FIFO, the result reader and the
//   downstream frame consumer.
//   FIFO side:
//     FIFO_EMPTY  - FIFO empty flag
//     FIFO_DATA   - read data, valid the cycle after FIFO_RD_EN
//     FIFO_RD_EN  - pop request
//   Result side (valid/ready):
//     RES_VALID, RES_READY, RES_MAC0, RES_MAC1, RES_INDEX
//
//   Handshake: a frame transfers on every rising edge where RES_VALID and
//   RES_READY are both high. Once RES_VALID rises it stays high, and
//   RES_MAC0/RES_MAC1/RES_INDEX stay constant, until that transfer edge.
//   RES_VALID never depends combinationally on RES_READY, and RES_READY
//   while RES_VALID is low has no effect.
//
//   master: the reader (drives FIFO_RD_EN and the RES_* payload)
//   slave : the environment (FIFO model and downstream consumer)
// -----------------------------------------------------------------------------
interface npu_result_reader_if;

    logic        FIFO_EMPTY;
    logic [7:0]  FIFO_DATA;
    logic        FIFO_RD_EN;
    logic        RES_VALID;
    logic        RES_READY;
    logic [15:0] RES_MAC0;
    logic [15:0] RES_MAC1;
    logic        RES_INDEX;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, RES_READY,
        output FIFO_RD_EN, RES_VALID, RES_MAC0, RES_MAC1, RES_INDEX
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DATA, RES_READY,
        input  FIFO_RD_EN, RES_VALID, RES_MAC0, RES_MAC1, RES_INDEX
    );

endinterface

// File: rtl/npu_result_reader_word_assembler.sv
// -----------------------------------------------------------------------------
// npu_word_assembler
//   Builds one 16-bit word from two bytes arriving high byte first.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     flush       - discard the partial word (word returns to 0)
//     load_hi     - capture byte_in into word[15:8]
//     load_lo     - capture byte_in into word[7:0]
//     byte_in     - byte from the FIFO read data
//     word        - assembled word (registered)
// -----------------------------------------------------------------------------
module npu_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load_hi,
    input  logic        load_lo,
    input  logic [7:0]  byte_in,
    output logic [15:0] word
);

    logic [15:0] word_q;
    logic [15:0] word_d;

    always_comb begin
        word_d = word_q;
        if (flush) begin
            word_d = 16'h0000;
        end else if (load_hi) begin
            word_d = {byte_in, word_q[7:0]};
        end else if (load_lo) begin
            word_d = {word_q[15:8], byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 16'h0000;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/npu_result_reader.sv
// -----------------------------------------------------------------------------
// npu_result_reader
//   Pops 4-byte result frames from the NPU output FIFO, reassembles them into
//   two signed 16-bit MAC words, computes the argmax index and presents the
//   frame downstream with a valid/ready handshake.
//   Ports:
//     CLKEXT          - clock (rising edge)
//     RST_GLO_N       - asynchronous active-low reset (deassertion already
//                       synchronised upstream)
//     EN              - allow new FIFO reads
//     CLR_ERR         - synchronous clear of ERR_TIMEOUT
//     bus             - FIFO + result bundle (master side)
//     FRAME_CNT       - frames accepted downstream, wraps 255 -> 0
//     ERR_TIMEOUT     - sticky partial-frame timeout flag
//     dbg_state       - current FSM state
//     dbg_bcnt        - bytes captured in the current frame
//     dbg_timeout_cnt - consecutive starved cycles mid-frame
//
//   Frame byte order: MAC0[15:8], MAC0[7:0], MAC1[15:8], MAC1[7:0].
//   Reads are pipelined: a byte requested in one cycle is captured at the end
//   of the next, while the following read may already be issued. A frame
//   therefore takes four read cycles, one cycle to capture the last byte and
//   one PRESENT cycle when the consumer is ready.
// -----------------------------------------------------------------------------
module npu_result_reader
    import npu_result_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 CLKEXT,
    input  logic                 RST_GLO_N,
    input  logic                 EN,
    input  logic                 CLR_ERR,
    npu_result_reader_if.master  bus,
    output logic [7:0]           FRAME_CNT,
    output logic                 ERR_TIMEOUT,
    output rr_state_e            dbg_state,
    output logic [BCNT_W-1:0]    dbg_bcnt,
    output logic [TO_W-1:0]      dbg_timeout_cnt
);

    // Counter value on the last tolerated starved cycle; reaching it fires.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      FRAME_BYTES_L = 3'(FRAME_BYTES);

    rr_state_e         state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              pend_q, pend_d;      // read issued last cycle, byte arrives now
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    logic              index_q, index_d;

    logic              rd_en;
    logic              timeout_hit;
    logic [2:0]        issued;
    logic              load_hi0, load_lo0, load_hi1, load_lo1;
    logic              flush;
    logic [15:0]       mac0, mac1;

    npu_word_assembler u_asm_mac0 (
        .clk     (CLKEXT),
        .rst_n   (RST_GLO_N),
        .flush   (flush),
        .load_hi (load_hi0),
        .load_lo (load_lo0),
        .byte_in (bus.FIFO_DATA),
        .word    (mac0)
    );

    npu_word_assembler u_asm_mac1 (
        .clk     (CLKEXT),
        .rst_n   (RST_GLO_N),
        .flush   (flush),
        .load_hi (load_hi1),
        .load_lo (load_lo1),
        .byte_in (bus.FIFO_DATA),
        .word    (mac1)
    );

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        pend_d      = 1'b0;
        to_d        = to_q;
        frame_cnt_d = frame_cnt_q;
        index_d     = index_q;
        rd_en       = 1'b0;
        timeout_hit = 1'b0;
        load_hi0    = 1'b0;
        load_lo0    = 1'b0;
        load_hi1    = 1'b0;
        load_lo1    = 1'b0;
        flush       = 1'b0;
        // Reads already spent on this frame: captured bytes plus one in flight.
        issued      = {1'b0, bcnt_q} + {2'b00, pend_q};

        case (state_q)
            FETCH: begin
                // Reset gating keeps the pop request low while reset is held.
                rd_en  = RST_GLO_N & EN & ~bus.FIFO_EMPTY & (issued < FRAME_BYTES_L);
                pend_d = rd_en;

                if (pend_q) begin
                    // In-flight byte lands regardless of EN.
                    to_d = '0;
                    case (bcnt_q)
                        2'd0:    load_hi0 = 1'b1;
                        2'd1:    load_lo0 = 1'b1;
                        2'd2:    load_hi1 = 1'b1;
                        default: load_lo1 = 1'b1;
                    endcase
                    if (bcnt_q == 2'd3) begin
                        state_d = PRESENT;
                        index_d = res_index_f(mac0, {mac1[15:8], bus.FIFO_DATA});
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else if (bcnt_q == '0) begin
                    to_d = '0;
                end else if (EN) begin
                    if (bus.FIFO_EMPTY) begin
                        if (to_q >= TO_LAST) begin
                            timeout_hit = 1'b1;
                            flush       = 1'b1;
                            bcnt_d      = '0;
                            to_d        = '0;
                        end else begin
                            to_d = to_q + 1'b1;
                        end
                    end else begin
                        to_d = '0;
                    end
                end
                // EN low mid-frame: partial frame and timeout count both hold.
            end

            PRESENT: begin
                if (bus.RES_READY) begin
                    state_d     = FETCH;
                    bcnt_d      = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = FETCH;
                bcnt_d  = '0;
            end
        endcase

        // Set wins over a same-cycle clear.
        err_d = timeout_hit | (err_q & ~CLR_ERR);
    end

    always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
        if (!RST_GLO_N) begin
            state_q     <= FETCH;
            bcnt_q      <= '0;
            pend_q      <= 1'b0;
            to_q        <= '0;
            frame_cnt_q <= 8'd0;
            err_q       <= 1'b0;
            index_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            pend_q      <= pend_d;
            to_q        <= to_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            index_q     <= index_d;
        end
    end

    assign bus.FIFO_RD_EN = rd_en;
    assign bus.RES_VALID  = (state_q == PRESENT);
    assign bus.RES_MAC0   = mac0;
    assign bus.RES_MAC1   = mac1;
    assign bus.RES_INDEX  = index_q;

    assign FRAME_CNT       = frame_cnt_q;
    assign ERR_TIMEOUT     = err_q;
    assign dbg_state       = state_q;
    assign dbg_bcnt        = bcnt_q;
    assign dbg_timeout_cnt = to_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// -----------------------------------------------------------------------------
// tb_npu_result_reader
//   Directed bench for npu_result_reader: FIFO model with one-cycle read
//   latency, consumer handshake driven from a single linear sequence.
// -----------------------------------------------------------------------------
module tb_npu_result_reader;
    import npu_result_reader_pkg::*;

    logic       CLKEXT;
    logic       RST_GLO_N;
    logic       EN;
    logic       CLR_ERR;
    logic [7:0] FRAME_CNT;
    logic       ERR_TIMEOUT;
    rr_state_e  dbg_state;
    logic [1:0] dbg_bcnt;
    logic [7:0] dbg_timeout_cnt;

    npu_result_reader_if bus ();

    npu_result_reader #(.TIMEOUT_CYCLES(16)) dut (
        .CLKEXT          (CLKEXT),
        .RST_GLO_N       (RST_GLO_N),
        .EN              (EN),
        .CLR_ERR         (CLR_ERR),
        .bus             (bus.master),
        .FRAME_CNT       (FRAME_CNT),
        .ERR_TIMEOUT     (ERR_TIMEOUT),
        .dbg_state       (dbg_state),
        .dbg_bcnt        (dbg_bcnt),
        .dbg_timeout_cnt (dbg_timeout_cnt)
    );

    // ---------------- clock ----------------
    initial CLKEXT = 1'b0;
    always #5 CLKEXT = ~CLKEXT;

    // ---------------- FIFO model ----------------
    logic [7:0] fifo_q[$];
    int         rd_cnt    = 0;
    int         underflow = 0;

    initial bus.FIFO_DATA = 8'h00;

    always @(posedge CLKEXT) begin
        if (bus.FIFO_RD_EN) begin
            if (fifo_q.size() > 0) begin
                bus.FIFO_DATA <= fifo_q.pop_front();
                rd_cnt = rd_cnt + 1;
            end else begin
                underflow = underflow + 1;
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: FIFO empty flag follows the queue shortly after the edge,
    // then return on the falling edge where outputs are sampled.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLKEXT);
            #1;
            bus.FIFO_EMPTY = (fifo_q.size() == 0);
            @(negedge CLKEXT);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        bus.FIFO_EMPTY = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && !bus.RES_VALID; i++) tick(1);
        check(tag, 32'(bus.RES_VALID), 32'd1);
    endtask

    task automatic accept();
        bus.RES_READY = 1'b1;
        tick(1);
        bus.RES_READY = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        RST_GLO_N      = 1'b0;
        EN             = 1'b0;
        CLR_ERR        = 1'b0;
        bus.RES_READY  = 1'b0;
        bus.FIFO_EMPTY = 1'b1;

        // Reset held with data queued and EN high: no pops, outputs zero.
        push(8'h12); push(8'h34); push(8'hFF); push(8'hF0);
        EN = 1'b1;
        @(negedge CLKEXT);
        tick(2);
        check("rst_rd_en",   32'(bus.FIFO_RD_EN), 32'd0);
        check("rst_rd_cnt",  32'(rd_cnt), 32'd0);
        check("rst_valid",   32'(bus.RES_VALID), 32'd0);
        check("rst_mac0",    32'(bus.RES_MAC0), 32'h0000);
        check("rst_mac1",    32'(bus.RES_MAC1), 32'h0000);
        check("rst_index",   32'(bus.RES_INDEX), 32'd0);
        check("rst_frames",  32'(FRAME_CNT), 32'd0);
        check("rst_err",     32'(ERR_TIMEOUT), 32'd0);
        check("rst_state",   32'(dbg_state), 32'(FETCH));

        // Nominal frame 12 34 FF F0.
        RST_GLO_N = 1'b1;
        wait_valid("nom_valid", 20);
        check("nom_mac0",    32'(bus.RES_MAC0), 32'h1234);
        check("nom_mac1",    32'(bus.RES_MAC1), 32'hFFF0);
        check("nom_index",   32'(bus.RES_INDEX), 32'd0);
        check("nom_reads",   32'(rd_cnt), 32'd4);
        accept();
        check("nom_frames",  32'(FRAME_CNT), 32'd1);
        check("nom_valid_lo", 32'(bus.RES_VALID), 32'd0);

        // Ready with nothing to present does nothing.
        bus.RES_READY = 1'b1;
        tick(3);
        bus.RES_READY = 1'b0;
        check("idle_ready_frames", 32'(FRAME_CNT), 32'd1);
        check("idle_ready_valid",  32'(bus.RES_VALID), 32'd0);

        // Backpressure with two frames queued.
        base = rd_cnt;
        push(8'h80); push(8'h00); push(8'h7F); push(8'hFF);
        push(8'h00); push(8'h05); push(8'h00); push(8'h05);
        wait_valid("bp_valid", 20);
        tick(10);
        check("bp_reads",    32'(rd_cnt - base), 32'd4);
        check("bp_rd_en",    32'(bus.FIFO_RD_EN), 32'd0);
        check("bp_hold",     32'(bus.RES_VALID), 32'd1);
        check("bp_mac0",     32'(bus.RES_MAC0), 32'h8000);
        check("bp_mac1",     32'(bus.RES_MAC1), 32'h7FFF);
        check("bp_index",    32'(bus.RES_INDEX), 32'd1);
        accept();
        check("bp_frames1",  32'(FRAME_CNT), 32'd2);
        wait_valid("bp_valid2", 20);
        check("bp_reads2",   32'(rd_cnt - base), 32'd8);
        check("tie_mac0",    32'(bus.RES_MAC0), 32'h0005);
        check("tie_mac1",    32'(bus.RES_MAC1), 32'h0005);
        check("tie_index",   32'(bus.RES_INDEX), 32'd0);
        accept();
        check("bp_frames2",  32'(FRAME_CNT), 32'd3);

        // Partial frame starves: two bytes, then empty.
        push(8'hAA); push(8'hBB);
        tick(12);
        check("to_early_err",  32'(ERR_TIMEOUT), 32'd0);
        check("to_early_bcnt", 32'(dbg_bcnt), 32'd2);
        tick(10);
        check("to_err",      32'(ERR_TIMEOUT), 32'd1);
        check("to_bcnt",     32'(dbg_bcnt), 32'd0);
        check("to_valid",    32'(bus.RES_VALID), 32'd0);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("clr_err",     32'(ERR_TIMEOUT), 32'd0);
        push(8'h00); push(8'h01); push(8'h00); push(8'h02);
        wait_valid("to_valid2", 20);
        check("to_mac0",     32'(bus.RES_MAC0), 32'h0001);
        check("to_mac1",     32'(bus.RES_MAC1), 32'h0002);
        check("to_index",    32'(bus.RES_INDEX), 32'd1);
        accept();
        check("to_frames",   32'(FRAME_CNT), 32'd4);

        // EN dropped after the first read of a frame.
        base = rd_cnt;
        push(8'h11);
        tick(1);
        EN = 1'b0;
        tick(40);
        check("en_reads",    32'(rd_cnt - base), 32'd1);
        check("en_err",      32'(ERR_TIMEOUT), 32'd0);
        check("en_bcnt",     32'(dbg_bcnt), 32'd1);
        check("en_to_cnt",   32'(dbg_timeout_cnt), 32'd0);
        push(8'h22); push(8'h33); push(8'h44);
        tick(5);
        check("en_reads2",   32'(rd_cnt - base), 32'd1);
        check("en_rd_en",    32'(bus.FIFO_RD_EN), 32'd0);
        EN = 1'b1;
        wait_valid("en_valid", 20);
        check("en_mac0",     32'(bus.RES_MAC0), 32'h1122);
        check("en_mac1",     32'(bus.RES_MAC1), 32'h3344);
        check("en_index",    32'(bus.RES_INDEX), 32'd1);
        check("en_reads3",   32'(rd_cnt - base), 32'd4);
        accept();
        check("en_frames",   32'(FRAME_CNT), 32'd5);

        // Reset mid-frame: two bytes popped, one still in flight.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick(2);
        RST_GLO_N = 1'b0;
        #1;
        check("mrst_frames", 32'(FRAME_CNT), 32'd0);
        check("mrst_mac0",   32'(bus.RES_MAC0), 32'h0000);
        check("mrst_bcnt",   32'(dbg_bcnt), 32'd0);
        check("mrst_rd_en",  32'(bus.FIFO_RD_EN), 32'd0);
        check("mrst_valid",  32'(bus.RES_VALID), 32'd0);
        fifo_q.delete();
        tick(2);
        RST_GLO_N = 1'b1;
        push(8'hFE); push(8'hDC); push(8'hBA); push(8'h98);
        wait_valid("mrst_valid2", 20);
        check("mrst_mac0b",  32'(bus.RES_MAC0), 32'hFEDC);
        check("mrst_mac1b",  32'(bus.RES_MAC1), 32'hBA98);
        check("mrst_index",  32'(bus.RES_INDEX), 32'd0);
        accept();
        check("mrst_frames2", 32'(FRAME_CNT), 32'd1);

        // 255 more frames back to back: counter reaches 255 then wraps to 0.
        for (int f = 0; f < 255; f++) begin
            for (int b = 0; b < 4; b++) push(8'(f + b));
        end
        bus.RES_READY = 1'b1;
        for (int i = 0; i < 4000 && FRAME_CNT != 8'd255; i++) tick(1);
        check("wrap_255",    32'(FRAME_CNT), 32'd255);
        for (int i = 0; i < 20 && FRAME_CNT != 8'd0; i++) tick(1);
        check("wrap_0",      32'(FRAME_CNT), 32'd0);
        check("wrap_drained", 32'(fifo_q.size()), 32'd0);
        bus.RES_READY = 1'b0;

        // Clear on the same edge the timeout fires: flag stays set.
        push(8'h5A);
        tick(17);
        check("cc_pre_err",  32'(ERR_TIMEOUT), 32'd0);
        check("cc_to_cnt",   32'(dbg_timeout_cnt), 32'd15);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("cc_err_set",  32'(ERR_TIMEOUT), 32'd1);
        check("cc_bcnt",     32'(dbg_bcnt), 32'd0);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("cc_err_clr",  32'(ERR_TIMEOUT), 32'd0);

        check("no_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
